// File: rtl/pc_fetch_ctrl.sv
// PC-load and instruction-fetch handshake controller with a one-entry redirect queue.
// Define PC_ALIGN_CHECK_EN to build the registered misaligned-fetch flag (adel_f).
module pc_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  input  logic        eret_req,
  input  logic [31:0] eret_target,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_cur,
  output logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        pc_en,
  output logic [31:0] pcnext,
  output logic        redir_taken,
  output logic [1:0]  redir_src,
  output logic        adel_f
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SRC_W  = 2;

  // Source codes double as priorities: a numerically larger code wins.
  localparam logic [SRC_W-1:0] SRC_NONE = 2'd0;
  localparam logic [SRC_W-1:0] SRC_BR   = 2'd1;
  localparam logic [SRC_W-1:0] SRC_ERET = 2'd2;
  localparam logic [SRC_W-1:0] SRC_EXC  = 2'd3;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [SRC_W-1:0]  src;
    logic [ADDR_W-1:0] target;
  } redir_t;

  state_t            state;
  state_t            state_nxt;
  redir_t            pend;
  redir_t            pend_nxt;
  redir_t            incoming;
  redir_t            winner;
  logic              inc_wins;
  logic              exc_seen;
  logic              fire;
  logic              inst_req_nxt;
  logic              pc_en_nxt;
  logic              redir_taken_nxt;
  logic [SRC_W-1:0]  redir_src_nxt;
  logic [ADDR_W-1:0] pcnext_nxt;

  // Fixed-priority pick among the redirect requests presented this cycle
  always_comb begin
    incoming = '0;
    if (exc_req) begin
      incoming.valid  = 1'b1;
      incoming.src    = SRC_EXC;
      incoming.target = exc_target;
    end else if (eret_req) begin
      incoming.valid  = 1'b1;
      incoming.src    = SRC_ERET;
      incoming.target = eret_target;
    end else if (br_req) begin
      incoming.valid  = 1'b1;
      incoming.src    = SRC_BR;
      incoming.target = br_target;
    end
  end

  // Ties go to the already-pending entry
  assign inc_wins = incoming.valid && (!pend.valid || (incoming.src > pend.src));
  assign winner   = inc_wins ? incoming : pend;
  assign exc_seen = exc_req || (pend.valid && (pend.src == SRC_EXC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pend        <= '0;
      inst_req    <= 1'b0;
      pc_en       <= 1'b0;
      pcnext      <= '0;
      redir_taken <= 1'b0;
      redir_src   <= SRC_NONE;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      inst_req    <= inst_req_nxt;
      pc_en       <= pc_en_nxt;
      pcnext      <= pcnext_nxt;
      redir_taken <= redir_taken_nxt;
      redir_src   <= redir_src_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    fire            = 1'b0;
    pend_nxt        = pend;
    inst_req_nxt    = 1'b0;
    pc_en_nxt       = 1'b0;
    pcnext_nxt      = pcnext;
    redir_taken_nxt = 1'b0;
    redir_src_nxt   = SRC_NONE;

    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        if (inst_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        // The outstanding fetch always completes; redirects only wait in the queue
        if (inst_data_ok) begin
          if (!stall || exc_seen) begin
            fire      = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall || exc_seen) begin
          fire      = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase

    if (fire) begin
      pend_nxt  = '0;
      pc_en_nxt = 1'b1;
      if (winner.valid) begin
        pcnext_nxt      = winner.target;
        redir_taken_nxt = 1'b1;
        redir_src_nxt   = winner.src;
      end else begin
        pcnext_nxt = pc_cur + PC_STEP;
      end
    end else if ((state != BOOT) && inc_wins) begin
      pend_nxt = incoming;
    end

    inst_req_nxt = (state_nxt == REQ);
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flag follows the alignment of the most recently loaded PC
  always_ff @(posedge clk) begin
    if (rst) begin
      adel_f <= 1'b0;
    end else if (fire) begin
      adel_f <= (pcnext_nxt[1:0] != 2'b00);
    end
  end
`else
  assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized fetches
// checked against a procedural redirect/PC model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exc_req;
  logic [31:0] exc_target;
  logic        eret_req;
  logic [31:0] eret_target;
  logic        br_req;
  logic [31:0] br_target;
  logic [31:0] pc_cur;
  logic        inst_req;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        pc_en;
  logic [31:0] pcnext;
  logic        redir_taken;
  logic [1:0]  redir_src;
  logic        adel_f;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the redirect still owed to the PC: best source seen since the last load
  logic [1:0]  m_src;
  logic [31:0] m_tgt;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .exc_req      (exc_req),
    .exc_target   (exc_target),
    .eret_req     (eret_req),
    .eret_target  (eret_target),
    .br_req       (br_req),
    .br_target    (br_target),
    .pc_cur       (pc_cur),
    .inst_req     (inst_req),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .pc_en        (pc_en),
    .pcnext       (pcnext),
    .redir_taken  (redir_taken),
    .redir_src    (redir_src),
    .adel_f       (adel_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_req  = 1'b0;
    eret_req = 1'b0;
    br_req   = 1'b0;
  endtask

  // Highest source asserted this cycle replaces the owed redirect only if strictly better
  task automatic model_offer();
    logic [1:0]  s;
    logic [31:0] t;
    s = 2'd0;
    t = '0;
    if (exc_req) begin s = 2'd3; t = exc_target; end
    else if (eret_req) begin s = 2'd2; t = eret_target; end
    else if (br_req) begin s = 2'd1; t = br_target; end
    if (s > m_src) begin
      m_src = s;
      m_tgt = t;
    end
  endtask

  task automatic set_req(input logic [1:0] src, input logic [31:0] tgt);
    case (src)
      2'd1: begin br_req = 1'b1; br_target = tgt; end
      2'd2: begin eret_req = 1'b1; eret_target = tgt; end
      2'd3: begin exc_req = 1'b1; exc_target = tgt; end
      default: ;
    endcase
    model_offer();
  endtask

  task automatic rand_req();
    exc_req     = ($urandom_range(0, 9) == 0);
    eret_req    = ($urandom_range(0, 7) == 0);
    br_req      = ($urandom_range(0, 4) == 0);
    exc_target  = $urandom();
    eret_target = $urandom();
    br_target   = $urandom();
    model_offer();
  endtask

  // One complete fetch starting with the DUT requesting; checks the resulting PC load
  task automatic run_fetch(input int addr_lat, input int data_lat, input int stall_len, input bit rnd);
    logic [31:0] exp_pc;
    logic [1:0]  exp_src;
    bit          fired;
    bit          exp_adel;
    int          hold;
    exp_pc  = '0;
    exp_src = 2'd0;
    for (int i = 0; i < addr_lat; i++) begin
      if (rnd) rand_req();
      tick();
      clear_req();
      n_checks++;
      if (inst_req !== 1'b1 || pc_en !== 1'b0)
        $display("FAIL req_hold: inst_req=%b pc_en=%b want 1/0", inst_req, pc_en);
      else n_pass++;
    end
    inst_addr_ok = 1'b1;
    if (rnd) rand_req();
    tick();
    inst_addr_ok = 1'b0;
    clear_req();
    n_checks++;
    if (inst_req !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL addr_accept: inst_req=%b pc_en=%b want 0/0", inst_req, pc_en);
    else n_pass++;
    for (int i = 0; i < data_lat; i++) begin
      if (rnd) rand_req();
      tick();
      clear_req();
      n_checks++;
      if (inst_req !== 1'b0 || pc_en !== 1'b0)
        $display("FAIL wait_idle: inst_req=%b pc_en=%b want 0/0", inst_req, pc_en);
      else n_pass++;
    end
    inst_data_ok = 1'b1;
    stall = (stall_len > 0);
    if (rnd) rand_req();
    fired = !stall || (m_src == 2'd3);
    if (fired) begin
      exp_pc  = (m_src != 2'd0) ? m_tgt : pc_cur + 32'd4;
      exp_src = m_src;
      m_src   = 2'd0;
    end
    tick();
    inst_data_ok = 1'b0;
    clear_req();
    hold = 1;
    while (!fired) begin
      n_checks++;
      if (pc_en !== 1'b0 || inst_req !== 1'b0)
        $display("FAIL hold_no_en: pc_en=%b inst_req=%b want 0/0", pc_en, inst_req);
      else n_pass++;
      stall = (hold < stall_len);
      hold++;
      if (rnd) rand_req();
      fired = !stall || (m_src == 2'd3);
      if (fired) begin
        exp_pc  = (m_src != 2'd0) ? m_tgt : pc_cur + 32'd4;
        exp_src = m_src;
        m_src   = 2'd0;
      end
      tick();
      clear_req();
    end
    stall = 1'b0;
    exp_adel = ALIGN_EN && (exp_pc[1:0] != 2'b00);
    n_checks++;
    if (pc_en !== 1'b1) $display("FAIL fetch_pc_en: got %b want 1", pc_en);
    else n_pass++;
    n_checks++;
    if (pcnext !== exp_pc) $display("FAIL fetch_pcnext: got %h want %h", pcnext, exp_pc);
    else n_pass++;
    n_checks++;
    if (redir_taken !== (exp_src != 2'd0) || redir_src !== exp_src)
      $display("FAIL fetch_redir: taken=%b src=%b want %b/%b", redir_taken, redir_src, exp_src != 2'd0, exp_src);
    else n_pass++;
    n_checks++;
    if (adel_f !== exp_adel) $display("FAIL fetch_adel: got %b want %b", adel_f, exp_adel);
    else n_pass++;
    pc_cur = exp_pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    br_req = 1'b1;
    br_target = 32'h12345678;
    tick();
    n_checks++;
    if ({pc_en, inst_req, redir_taken, redir_src, adel_f} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {pc_en, inst_req, redir_taken, redir_src, adel_f});
    else n_pass++;
    rst = 1'b0;
    tick();
    clear_req();
    n_checks++;
    if (inst_req !== 1'b1 || pc_en !== 1'b0)
      $display("FAIL boot_one_cycle: inst_req=%b pc_en=%b want 1/0", inst_req, pc_en);
    else n_pass++;
    m_src = 2'd0;
  endtask

  task automatic test_boot_fetch();
    pc_cur = 32'hbfc00000;
    run_fetch(0, 0, 0, 1'b0);
    n_checks++;
    if (pc_cur !== 32'hbfc00004 || pcnext !== 32'hbfc00004)
      $display("FAIL boot_fetch_pc: got %h want bfc00004", pcnext);
    else n_pass++;
  endtask

  task automatic test_branch_wait();
    pc_cur = 32'h00400000;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    set_req(2'd1, 32'h80001000);
    tick();
    clear_req();
    n_checks++;
    if (inst_req !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL br_wait_no_abort: inst_req=%b pc_en=%b want 0/0", inst_req, pc_en);
    else n_pass++;
    inst_data_ok = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    n_checks++;
    if (pc_en !== 1'b1 || pcnext !== 32'h80001000)
      $display("FAIL br_wait_pc: pc_en=%b pcnext=%h want 1/80001000", pc_en, pcnext);
    else n_pass++;
    n_checks++;
    if (redir_taken !== 1'b1 || redir_src !== 2'b01)
      $display("FAIL br_wait_src: taken=%b src=%b want 1/01", redir_taken, redir_src);
    else n_pass++;
    m_src  = 2'd0;
    pc_cur = 32'h80001000;
    run_fetch(1, 0, 0, 1'b0);
  endtask

  task automatic test_priority();
    logic [1:0]  s1, s2, es;
    logic [31:0] t1, t2, et;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin s1 = 2'd1; t1 = 32'h80001000; s2 = 2'd3; t2 = 32'hbfc00380; es = 2'd3; et = 32'hbfc00380; end
        1: begin s1 = 2'd3; t1 = 32'hbfc00380; s2 = 2'd1; t2 = 32'h80001000; es = 2'd3; et = 32'hbfc00380; end
        2: begin s1 = 2'd1; t1 = 32'h80002000; s2 = 2'd2; t2 = 32'h80003000; es = 2'd2; et = 32'h80003000; end
        3: begin s1 = 2'd2; t1 = 32'h80003000; s2 = 2'd2; t2 = 32'h80004000; es = 2'd2; et = 32'h80003000; end
        default: begin s1 = 2'd1; t1 = 32'h80005000; s2 = 2'd1; t2 = 32'h80006000; es = 2'd1; et = 32'h80005000; end
      endcase
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      set_req(s1, t1);
      tick();
      clear_req();
      set_req(s2, t2);
      tick();
      clear_req();
      inst_data_ok = 1'b1;
      tick();
      inst_data_ok = 1'b0;
      n_checks++;
      if (pc_en !== 1'b1 || pcnext !== et || redir_src !== es)
        $display("FAIL priority_%0d: pc_en=%b pcnext=%h src=%b want 1/%h/%b", k, pc_en, pcnext, redir_src, et, es);
      else n_pass++;
      m_src  = 2'd0;
      pc_cur = et;
    end
  endtask

  task automatic test_hold_exc();
    pc_cur = 32'h00400100;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    stall = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    n_checks++;
    if (pc_en !== 1'b0) $display("FAIL hold_entry: pc_en=%b want 0", pc_en);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_en !== 1'b0 || inst_req !== 1'b0)
      $display("FAIL hold_stay: pc_en=%b inst_req=%b want 0/0", pc_en, inst_req);
    else n_pass++;
    set_req(2'd3, 32'hbfc00380);
    tick();
    clear_req();
    n_checks++;
    if (pc_en !== 1'b1 || pcnext !== 32'hbfc00380 || redir_src !== 2'b11)
      $display("FAIL hold_exc: pc_en=%b pcnext=%h src=%b want 1/bfc00380/11", pc_en, pcnext, redir_src);
    else n_pass++;
    stall  = 1'b0;
    m_src  = 2'd0;
    pc_cur = 32'hbfc00380;
    // Branch captured while held, then taken on stall release
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    stall = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    set_req(2'd1, 32'h80002000);
    tick();
    clear_req();
    n_checks++;
    if (pc_en !== 1'b0) $display("FAIL hold_br_wait: pc_en=%b want 0", pc_en);
    else n_pass++;
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc_en !== 1'b1 || pcnext !== 32'h80002000 || redir_src !== 2'b01)
      $display("FAIL hold_release: pc_en=%b pcnext=%h src=%b want 1/80002000/01", pc_en, pcnext, redir_src);
    else n_pass++;
    m_src  = 2'd0;
    pc_cur = 32'h80002000;
  endtask

  task automatic test_reset_in_wait();
    pc_cur = 32'h00400200;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    set_req(2'd1, 32'h80007000);
    tick();
    clear_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({pc_en, inst_req, redir_taken, redir_src, adel_f} !== 6'b0)
      $display("FAIL rst_wait_clear: got %b want 000000", {pc_en, inst_req, redir_taken, redir_src, adel_f});
    else n_pass++;
    m_src = 2'd0;
    inst_data_ok = 1'b1;
    tick();
    n_checks++;
    if (pc_en !== 1'b0 || inst_req !== 1'b1)
      $display("FAIL boot_ignores_data_ok: pc_en=%b inst_req=%b want 0/1", pc_en, inst_req);
    else n_pass++;
    tick();
    inst_data_ok = 1'b0;
    n_checks++;
    if (pc_en !== 1'b0 || inst_req !== 1'b1)
      $display("FAIL req_ignores_data_ok: pc_en=%b inst_req=%b want 0/1", pc_en, inst_req);
    else n_pass++;
    run_fetch(0, 1, 0, 1'b0);
  endtask

  task automatic test_align();
    logic exp_flag;
    exp_flag = ALIGN_EN;
    pc_cur = 32'h00400300;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    set_req(2'd1, 32'h80001002);
    tick();
    clear_req();
    inst_data_ok = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    n_checks++;
    if (pcnext !== 32'h80001002) $display("FAIL align_pc_unchanged: got %h want 80001002", pcnext);
    else n_pass++;
    n_checks++;
    if (adel_f !== exp_flag) $display("FAIL align_flag_set: got %b want %b", adel_f, exp_flag);
    else n_pass++;
    m_src = 2'd0;
    tick();
    n_checks++;
    if (adel_f !== exp_flag) $display("FAIL align_flag_held: got %b want %b", adel_f, exp_flag);
    else n_pass++;
    pc_cur = 32'h80001000;
    run_fetch(0, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    pc_cur = 32'hfffffffc;
    run_fetch(0, 0, 0, 1'b0);
    n_checks++;
    if (pcnext !== 32'h00000000) $display("FAIL wrap_pc: got %h want 00000000", pcnext);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pc_cur = 32'h00001000;
    for (int i = 0; i < 4; i++) run_fetch(0, 0, 0, 1'b0);
    n_checks++;
    if (pcnext !== 32'h00001010) $display("FAIL back_to_back_pc: got %h want 00001010", pcnext);
    else n_pass++;
  endtask

  task automatic test_random();
    pc_cur = $urandom();
    for (int i = 0; i < 150; i++) begin
      run_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)), 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    exc_req      = 1'b0;
    eret_req     = 1'b0;
    br_req       = 1'b0;
    exc_target   = '0;
    eret_target  = '0;
    br_target    = '0;
    pc_cur       = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    m_src        = 2'd0;
    m_tgt        = '0;
    test_reset();
    test_boot_fetch();
    test_branch_wait();
    test_priority();
    test_hold_exc();
    test_reset_in_wait();
    test_align();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: stall  in  1  pipeline stall from hazard unit; blocks sequential PC advance.
REQ-004 SHALL have ports: exc_req  in  1 / exc_target  in  32  exception redirect (highest priority).
REQ-005 SHALL have ports: eret_req  in  1 / eret_target  in  32  ERET redirect (middle priority).
REQ-006 SHALL have ports: br_req  in  1 / br_target  in  32  branch/jump redirect (lowest priority).
REQ-007 SHALL have ports: pc_cur  in  32  current PC register value.
REQ-008 SHALL have ports: inst_req  out  1 / inst_addr_ok  in  1 / inst_data_ok  in  1  instruction-bus handshake.
REQ-009 SHALL have ports: pc_en  out  1 / pcnext  out  32  load strobe and value for the PC register.
REQ-010 SHALL have ports: redir_taken  out  1 / redir_src  out  2  pulse when pcnext is a redirect; src 01=br, 10=eret, 11=exc, 00=none.
REQ-011 SHALL have ports: adel_f  out  1  misaligned-fetch flag (see Configuration).

Function
REQ-012 SHALL implement FSM states BOOT, REQ, WAIT, HOLD.
REQ-013 BOOT: pc_en=0, inst_req=0; one cycle, then REQ unconditionally (PC register loads 32'hbfc00000 itself).
REQ-014 REQ: inst_req=1; inst_addr_ok=1 -> WAIT; else stay in REQ.
REQ-015 WAIT: inst_req=0; no new request issued and no redirect may abort the outstanding transaction.
REQ-016 WAIT with inst_data_ok=1: if stall=0 or a pending/incoming exc exists -> pc_en=1, go to REQ; else -> HOLD.
REQ-017 HOLD: pc_en=0 until stall=0 or exc present, then pc_en=1 for one cycle, go to REQ.
REQ-018 pc_en SHALL be asserted only on transitions to REQ from WAIT or HOLD; it is never asserted in BOOT or REQ.
REQ-019 Single pending-redirect register (valid, src, target); request arriving in REQ/WAIT/HOLD without a same-cycle pc_en SHALL be captured.
REQ-020 Priority exc > eret > br; a higher-priority request overwrites the pending entry, while an equal- or lower-priority request is dropped.
REQ-021 pcnext SHALL be, in order: winner of pending vs incoming by priority; else pc_cur+4 (32-bit wrap, 32'hfffffffc+4=0).
REQ-022 A request in the same cycle as pc_en SHALL be used directly if it wins and SHALL NOT be stored; the pending entry is cleared whenever pc_en=1.
REQ-023 redir_taken=1 and redir_src SHALL be valid only in the pc_en cycle whose pcnext is a redirect.
REQ-024 Requests during BOOT SHALL be ignored.

Reset
REQ-025 rst=1 SHALL force state BOOT, clear the pending entry, and drive pc_en=0, inst_req=0, redir_taken=0, redir_src=0, adel_f=0 in the following cycle.
REQ-026 A reset in WAIT SHALL abandon the transaction; a stray inst_data_ok during BOOT/REQ after reset SHALL be ignored.

Configuration
REQ-027 Macro PC_ALIGN_CHECK_EN: when defined, adel_f SHALL be registered 1 on each pc_en where pcnext[1:0]!=0 and cleared on the next pc_en with an aligned pcnext; pcnext is still loaded unchanged.
REQ-028 Without PC_ALIGN_CHECK_EN, adel_f SHALL be constant 0 and no check logic is built.

Verification
REQ-029 Reset, then addr_ok/data_ok each 1 cycle later, stall=0, pc_cur=bfc00000 -> BOOT 1 cycle, inst_req, pc_en pulse with pcnext=bfc00004, redir_taken=0.
REQ-030 br_req with target 80001000 during WAIT -> captured; at data_ok pcnext=80001000, redir_src=01, pending cleared.
REQ-031 br_req in WAIT, then exc_req (target bfc00380) one cycle later -> pcnext=bfc00380, src=11; reverse order (exc then br) -> still bfc00380.
REQ-032 stall=1 at data_ok -> HOLD, pc_en stays 0; exc_req during HOLD -> pc_en=1 next cycle despite stall, pcnext=exc_target.
REQ-033 rst asserted in WAIT, then data_ok pulsed during BOOT -> no pc_en, the pending entry stays empty, and normal fetch resumes from REQ.
REQ-034 With PC_ALIGN_CHECK_EN, br_target 80001002 -> adel_f=1 after pc_en; next aligned pc_en -> adel_f=0; without the macro, adel_f stays 0.
